// File: rtl/sal_axi_wr_frontend.sv
// AXI write-slave front-end: accepts one AW burst at a time, turns each W beat into a
// scheduler write request, and returns a single B response when the beat count completes.
module sal_axi_wr_frontend #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_avalid,
    output logic                o_aready,
    input  logic [ID_W-1:0]     i_aid,
    input  logic [ADDR_W-1:0]   i_aaddr,
    input  logic [LEN_W-1:0]    i_alen,
    input  logic [2:0]          i_asize,
    input  logic [1:0]          i_aburst,
    input  logic                i_wvalid,
    output logic                o_wready,
    input  logic [ID_W-1:0]     i_wid,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_req_valid,
    input  logic                i_req_ready,
    output logic [ADDR_W-1:0]   o_req_addr,
    output logic [DATA_W-1:0]   o_req_data,
    output logic [DATA_W/8-1:0] o_req_strb,
    output logic [ID_W-1:0]     o_req_id,
    output logic                o_req_last
);

    typedef enum logic [1:0] {INIT, IDLE, DATA, RESP} state_t;

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    state_t              r_state, w_next;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic [LEN_W-1:0]    r_beatCnt;
    logic                r_err;
    logic                r_drain;

    logic                w_awHs;
    logic                w_wHs;
    logic                w_lastBeat;
    logic                w_awBad;
    logic [ADDR_W-1:0]   w_beatBytes;
    logic [ADDR_W-1:0]   w_nextAddr;

    assign w_awHs      = i_avalid && o_aready;
    assign w_wHs       = i_wvalid && o_wready;
    assign w_lastBeat  = (r_beatCnt == r_len);
    assign w_awBad     = !(i_aburst == BURST_FIXED || i_aburst == BURST_INCR) || (i_asize > MAX_SIZE);
    assign w_beatBytes = {{(ADDR_W-1){1'b0}}, 1'b1} << r_size;
    assign w_nextAddr  = (r_burst == BURST_INCR) ? ((r_addr & ~(w_beatBytes - 1'b1)) + w_beatBytes) : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus all handshake outputs; a drained (error) burst swallows W without issuing.
    always_comb begin
        w_next      = r_state;
        o_aready    = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        o_req_valid = 1'b0;
        case (r_state)
            INIT: w_next = IDLE;
            IDLE: begin
                o_aready = 1'b1;
                if (i_avalid) w_next = DATA;
            end
            DATA: begin
                o_wready    = r_drain ? 1'b1 : i_req_ready;
                o_req_valid = !r_drain && i_wvalid;
                if (w_wHs && w_lastBeat) w_next = RESP;
            end
            RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_next = IDLE;
            end
            default: w_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beatCnt <= '0;
            r_err     <= 1'b0;
            r_drain   <= 1'b0;
        end else if (w_awHs) begin
            r_id      <= i_aid;
            r_addr    <= i_aaddr;
            r_len     <= i_alen;
            r_size    <= i_asize;
            r_burst   <= i_aburst;
            r_beatCnt <= '0;
            r_err     <= w_awBad;
            r_drain   <= w_awBad;
        end else if (w_wHs) begin
            r_beatCnt <= r_beatCnt + 1'b1;
            r_addr    <= w_nextAddr;
            // Protocol slips on a good burst only poison the response; the beat is still issued.
            if (!r_drain && (i_wid != r_id || i_wlast != w_lastBeat)) r_err <= 1'b1;
        end
    end

    assign o_bid      = (r_state == RESP) ? r_id : '0;
    assign o_bresp    = (r_state == RESP && r_err) ? 2'd2 : 2'd0;
    assign o_req_addr = r_addr;
    assign o_req_data = i_wdata;
    assign o_req_strb = i_wstrb;
    assign o_req_id   = r_id;
    assign o_req_last = w_lastBeat;

endmodule

// File: tb/tb_sal_axi_wr_frontend.sv
// Scoreboard bench for sal_axi_wr_frontend: directed bursts push expected requests and
// B responses into queues that an independent negedge monitor pops and compares.
module tb_sal_axi_wr_frontend;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
        logic [3:0]   id;
        logic         last;
    } req_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_avalid = 1'b0;
    logic         o_aready;
    logic [3:0]   i_aid = '0;
    logic [31:0]  i_aaddr = '0;
    logic [3:0]   i_alen = '0;
    logic [2:0]   i_asize = '0;
    logic [1:0]   i_aburst = '0;
    logic         i_wvalid = 1'b0;
    logic         o_wready;
    logic [3:0]   i_wid = '0;
    logic [127:0] i_wdata = '0;
    logic [15:0]  i_wstrb = '0;
    logic         i_wlast = 1'b0;
    logic         o_bvalid;
    logic         i_bready = 1'b1;
    logic [3:0]   o_bid;
    logic [1:0]   o_bresp;
    logic         o_req_valid;
    logic         i_req_ready = 1'b1;
    logic [31:0]  o_req_addr;
    logic [127:0] o_req_data;
    logic [15:0]  o_req_strb;
    logic [3:0]   o_req_id;
    logic         o_req_last;

    int   checks = 0;
    int   errors = 0;
    int   beatSeq = 0;
    req_t reqQ[$];
    b_t   bQ[$];
    logic toggleReady = 1'b0;
    logic expectMirror = 1'b0;

    sal_axi_wr_frontend dut (
        .clk(clk), .rst_n(rst_n),
        .i_avalid(i_avalid), .o_aready(o_aready), .i_aid(i_aid), .i_aaddr(i_aaddr),
        .i_alen(i_alen), .i_asize(i_asize), .i_aburst(i_aburst),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wid(i_wid), .i_wdata(i_wdata),
        .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
        .o_req_data(o_req_data), .o_req_strb(o_req_strb), .o_req_id(o_req_id),
        .o_req_last(o_req_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Toggles req_ready each cycle when asked, otherwise leaves the driven level alone.
    always @(posedge clk) begin
        #1;
        if (toggleReady) i_req_ready = ~i_req_ready;
    end

    // Monitor: sampled mid-cycle, away from the edge where handshakes complete.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_req_valid && reqQ.size() == 0) begin
                checkOutput("unexpected_req", 1'b1, 1'b0);
            end else if (o_req_valid && i_req_ready) begin
                req_t e;
                e = reqQ.pop_front();
                checkOutput("req_addr", o_req_addr, e.addr);
                checkOutput("req_data", o_req_data, e.data);
                checkOutput("req_strb", o_req_strb, e.strb);
                checkOutput("req_id", o_req_id, e.id);
                checkOutput("req_last", o_req_last, e.last);
            end
            if (o_bvalid && i_bready) begin
                if (bQ.size() == 0) begin
                    checkOutput("unexpected_b", 1'b1, 1'b0);
                end else begin
                    b_t b;
                    b = bQ.pop_front();
                    checkOutput("bid", o_bid, b.id);
                    checkOutput("bresp", o_bresp, b.resp);
                end
            end
            if (expectMirror) checkOutput("wready_mirror", o_wready, i_req_ready);
        end
    end

    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        bit done = 0;
        i_aid = id; i_aaddr = addr; i_alen = len; i_asize = size; i_aburst = burst;
        i_avalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (o_aready) done = 1;
        end
        if (!done) checkOutput("aw_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        i_avalid = 1'b0;
    endtask

    task automatic sendBeat(input logic [3:0] wid, input logic wlast, input logic issue,
                            input logic [31:0] expAddr, input logic [3:0] expId, input logic expLast);
        bit done = 0;
        req_t e;
        beatSeq++;
        i_wid   = wid;
        i_wlast = wlast;
        i_wdata = {4{32'hA5C3_0000 ^ 32'(beatSeq)}};
        i_wstrb = 16'hFFFF ^ 16'(beatSeq * 3);
        if (issue) begin
            e.addr = expAddr; e.data = i_wdata; e.strb = i_wstrb; e.id = expId; e.last = expLast;
            reqQ.push_back(e);
        end
        i_wvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!issue && i == 0) checkOutput("drain_wready", o_wready, 1'b1);
            if (o_wready) done = 1;
        end
        if (!done) checkOutput("w_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        i_wvalid = 1'b0;
    endtask

    task automatic expectB(input logic [3:0] id, input logic [1:0] resp);
        b_t b;
        b.id = id; b.resp = resp;
        bQ.push_back(b);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && (reqQ.size() != 0 || bQ.size() != 0); i++) @(posedge clk);
        checkOutput("req_queue_empty", 32'(reqQ.size()), 32'd0);
        checkOutput("b_queue_empty", 32'(bQ.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset behaviour and the single INIT cycle
        repeat (3) @(negedge clk);
        checkOutput("rst_aready", o_aready, 1'b0);
        checkOutput("rst_wready", o_wready, 1'b0);
        checkOutput("rst_bvalid", o_bvalid, 1'b0);
        checkOutput("rst_req_valid", o_req_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("aready_after_release", o_aready, 1'b1);

        $display("[TB] INCR burst alen=3");
        applyStimulus(4'd5, 32'h1008, 4'd3, 3'd4, 2'd1);
        expectB(4'd5, 2'd0);
        sendBeat(4'd5, 1'b0, 1'b1, 32'h1008, 4'd5, 1'b0);
        sendBeat(4'd5, 1'b0, 1'b1, 32'h1010, 4'd5, 1'b0);
        sendBeat(4'd5, 1'b0, 1'b1, 32'h1020, 4'd5, 1'b0);
        sendBeat(4'd5, 1'b1, 1'b1, 32'h1030, 4'd5, 1'b1);
        waitDrain();

        $display("[TB] FIXED burst with toggling req_ready");
        applyStimulus(4'd1, 32'h40, 4'd1, 3'd2, 2'd0);
        expectB(4'd1, 2'd0);
        toggleReady = 1'b1;
        expectMirror = 1'b1;
        sendBeat(4'd1, 1'b0, 1'b1, 32'h40, 4'd1, 1'b0);
        sendBeat(4'd1, 1'b1, 1'b1, 32'h40, 4'd1, 1'b1);
        expectMirror = 1'b0;
        toggleReady = 1'b0;
        i_req_ready = 1'b0;
        waitDrain();

        $display("[TB] WRAP burst drained with req_ready low");
        applyStimulus(4'd7, 32'h80, 4'd3, 3'd4, 2'd2);
        expectB(4'd7, 2'd2);
        for (int i = 0; i < 4; i++) sendBeat(4'd7, (i == 3), 1'b0, 32'h0, 4'd0, 1'b0);
        waitDrain();

        $display("[TB] oversize asize drained");
        applyStimulus(4'd9, 32'h100, 4'd0, 3'd5, 2'd1);
        expectB(4'd9, 2'd2);
        sendBeat(4'd9, 1'b1, 1'b0, 32'h0, 4'd0, 1'b0);
        i_req_ready = 1'b1;
        waitDrain();

        $display("[TB] address wrap at top of space");
        applyStimulus(4'd3, 32'hFFFF_FFF0, 4'd0, 3'd4, 2'd1);
        expectB(4'd3, 2'd0);
        sendBeat(4'd3, 1'b1, 1'b1, 32'hFFFF_FFF0, 4'd3, 1'b1);
        applyStimulus(4'd3, 32'hFFFF_FFF0, 4'd1, 3'd4, 2'd1);
        expectB(4'd3, 2'd0);
        sendBeat(4'd3, 1'b0, 1'b1, 32'hFFFF_FFF0, 4'd3, 1'b0);
        sendBeat(4'd3, 1'b1, 1'b1, 32'h0000_0000, 4'd3, 1'b1);
        waitDrain();

        $display("[TB] early wlast and wrong wid");
        applyStimulus(4'd2, 32'h200, 4'd2, 3'd4, 2'd1);
        expectB(4'd2, 2'd2);
        sendBeat(4'd3, 1'b0, 1'b1, 32'h200, 4'd2, 1'b0);
        sendBeat(4'd3, 1'b1, 1'b1, 32'h210, 4'd2, 1'b0);
        sendBeat(4'd3, 1'b0, 1'b1, 32'h220, 4'd2, 1'b1);
        waitDrain();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(4'd4, 32'h300, 4'd3, 3'd4, 2'd1);
        sendBeat(4'd4, 1'b0, 1'b1, 32'h300, 4'd4, 1'b0);
        sendBeat(4'd4, 1'b0, 1'b1, 32'h310, 4'd4, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_bvalid", o_bvalid, 1'b0);
            checkOutput("midrst_aready", o_aready, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("aready_after_midrst", o_aready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_b_after_midrst", o_bvalid, 1'b0);
        end
        @(posedge clk); #1;
        applyStimulus(4'd6, 32'h500, 4'd0, 3'd4, 2'd1);
        expectB(4'd6, 2'd0);
        sendBeat(4'd6, 1'b1, 1'b1, 32'h500, 4'd6, 1'b1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
